// File: rtl/arc_mem_arbiter_if.sv
// Bundle of the fetch, load/store and external-memory signals around arc_mem_arbiter.
// slave = arbiter side, master = requesters plus memory (bench) side.
interface arc_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              ack;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, ack,
    output if_rdata, if_done, if_err, d_rdata, d_done, d_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, ack,
    input  if_rdata, if_done, if_err, d_rdata, d_done, d_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arc_mem_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack memory port between fetch and load/store.
// Grant one cycle after req; done/err pulse one cycle after ack or timeout; all outputs registered.
module arc_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  arc_mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic [1:0]        r_state;
  logic              r_owner;      // 1 = load/store owns the port
  logic              r_last;       // 1 = load/store was granted last
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_if_done;
  logic              r_if_err;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_d_done;
  logic              r_d_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_any;
  logic w_grant_d;
  logic w_cnt_last;
  logic w_cnt_sat;

  always_comb begin
    w_any      = bus.if_req | bus.d_req;
    w_grant_d  = bus.d_req & (~bus.if_req | ~r_last);
    w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));
    w_cnt_sat  = &r_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_if_rdata  <= '0;
      r_if_done   <= 1'b0;
      r_if_err    <= 1'b0;
      r_d_rdata   <= '0;
      r_d_done    <= 1'b0;
      r_d_err     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_done <= 1'b0;
      r_if_err  <= 1'b0;
      r_d_done  <= 1'b0;
      r_d_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner    <= w_grant_d;
            r_last     <= w_grant_d;
            r_mem_addr <= w_grant_d ? bus.d_addr : bus.if_addr;
            r_mem_we   <= w_grant_d & bus.d_we;
            if (w_grant_d) r_mem_wdata <= bus.d_wdata;
            r_mem_req  <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_REL;
            if (r_owner) begin
              r_d_rdata <= bus.mem_rdata;
              r_d_done  <= 1'b1;
            end else begin
              r_if_rdata <= bus.mem_rdata;
              r_if_done  <= 1'b1;
            end
          end else if (w_cnt_last) begin
            r_mem_req <= 1'b0;
            r_state   <= S_REL;
            if (r_owner) begin
              r_d_rdata <= '0;
              r_d_done  <= 1'b1;
              r_d_err   <= 1'b1;
            end else begin
              r_if_rdata <= '0;
              r_if_done  <= 1'b1;
              r_if_err   <= 1'b1;
            end
          end else if (!w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Stay here until the memory drops ack so a stale ack never completes a new request.
        S_REL: begin
          if (!bus.ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_done   = r_if_done;
  assign bus.if_err    = r_if_err;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.d_err     = r_d_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_arc_mem_arbiter.sv
// Directed bench for arc_mem_arbiter: stimulus pushes expected completions, a monitor pops them on done.
module tb_arc_mem_arbiter;

  typedef struct packed {
    logic        is_data;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  arc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

  arc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (b.if_done || b.d_done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: if_done=%0b d_done=%0b, none expected at %0t",
                   b.if_done, b.d_done, $time);
        end else begin
          e = sb.pop_front();
          check("done_owner", {31'd0, b.d_done}, {31'd0, e.is_data});
          check("both_done", {31'd0, b.if_done & b.d_done}, 32'd0);
          check("done_err", {31'd0, e.is_data ? b.d_err : b.if_err}, {31'd0, e.err});
          check("done_rdata", e.is_data ? b.d_rdata : b.if_rdata, e.rdata);
        end
      end
      if ((b.if_err && !b.if_done) || (b.d_err && !b.d_done)) begin
        total++;
        bad++;
        $display("FAIL stray_err: if_err=%0b d_err=%0b without done", b.if_err, b.d_err);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_mem_req", {31'd0, b.mem_req}, 32'd0);
    check("rst_mem_addr", b.mem_addr, 32'd0);
    check("rst_if_rdata", b.if_rdata, 32'd0);
    check("rst_d_rdata", b.d_rdata, 32'd0);
    rst = 1'b1;
  endtask

  // Wait for a grant, check who got it, answer with ack after lat cycles.
  task automatic serve(input int lat, input logic [31:0] rd, input logic is_data,
                       input logic [31:0] exp_addr, input logic drop);
    int n = 0;
    while (!b.mem_req && n < 20) begin
      tick();
      n++;
    end
    if (!b.mem_req) begin
      total++;
      bad++;
      $display("FAIL serve_grant: mem_req still 0 after %0d cycles, want 1", n);
      return;
    end
    check("grant_addr", b.mem_addr, exp_addr);
    sb.push_back('{is_data, 1'b0, rd});
    repeat (lat - 1) tick();
    b.ack = 1'b1;
    b.mem_rdata = rd;
    tick();
    check("req_drop_on_ack", {31'd0, b.mem_req}, 32'd0);
    if (drop) begin
      b.if_req = 1'b0;
      b.d_req = 1'b0;
    end
    tick();
    b.ack = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b.if_req = 0; b.if_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0;
    b.d_wdata = 0; b.mem_rdata = 0; b.ack = 0;
    fork
      monitor();
    join_none
    do_reset();
    check("rst_if_done", {31'd0, b.if_done}, 32'd0);
    check("rst_mem_we", {31'd0, b.mem_we}, 32'd0);
    tick();

    // Fetch read, ack four cycles after mem_req and held for two cycles
    b.if_req = 1'b1;
    b.if_addr = 32'h100;
    tick();
    check("fetch_req_latency", {31'd0, b.mem_req}, 32'd1);
    check("fetch_addr", b.mem_addr, 32'h100);
    check("fetch_we", {31'd0, b.mem_we}, 32'd0);
    sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
    repeat (3) tick();
    b.ack = 1'b1;
    b.mem_rdata = 32'hDEADBEEF;
    tick();
    check("fetch_done", {31'd0, b.if_done}, 32'd1);
    check("fetch_req_low", {31'd0, b.mem_req}, 32'd0);
    b.if_req = 1'b0;
    tick();
    check("fetch_release_req", {31'd0, b.mem_req}, 32'd0);
    b.ack = 1'b0;
    repeat (2) tick();

    // Store: address/data/we must stay stable while BUSY
    b.d_req = 1'b1;
    b.d_we = 1'b1;
    b.d_addr = 32'h200;
    b.d_wdata = 32'h12345678;
    tick();
    check("store_req", {31'd0, b.mem_req}, 32'd1);
    sb.push_back('{1'b1, 1'b0, 32'hA5A5A5A5});
    for (int i = 0; i < 3; i++) begin
      b.d_addr = 32'hFFFF0000;
      b.d_wdata = 32'h0BADF00D;
      check("store_we", {31'd0, b.mem_we}, 32'd1);
      check("store_addr", b.mem_addr, 32'h200);
      check("store_wdata", b.mem_wdata, 32'h12345678);
      tick();
    end
    b.ack = 1'b1;
    b.mem_rdata = 32'hA5A5A5A5;
    tick();
    check("store_done", {31'd0, b.d_done}, 32'd1);
    b.d_req = 1'b0;
    b.d_we = 1'b0;
    b.ack = 1'b0;
    repeat (2) tick();

    // Conflict from reset: grants alternate fetch, data, fetch, ...
    b.if_req = 1'b1;
    b.if_addr = 32'h300;
    b.d_req = 1'b1;
    b.d_addr = 32'h400;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      serve(3, 32'h1000 + i, i[0], i[0] ? 32'h400 : 32'h300, i == 9);
      repeat (2) tick();
    end
    repeat (2) tick();

    // Timeout: no ack, done+err exactly 8 cycles after mem_req rose
    b.d_req = 1'b1;
    b.d_addr = 32'h600;
    tick();
    check("to_req", {31'd0, b.mem_req}, 32'd1);
    sb.push_back('{1'b1, 1'b1, 32'd0});
    repeat (7) tick();
    check("to_not_early", {31'd0, b.d_done}, 32'd0);
    tick();
    check("to_done", {31'd0, b.d_done}, 32'd1);
    check("to_err", {31'd0, b.d_err}, 32'd1);
    b.d_req = 1'b0;
    repeat (2) tick();
    b.ack = 1'b1;
    b.mem_rdata = 32'h77777777;
    repeat (2) tick();
    b.ack = 1'b0;
    repeat (3) tick();

    // Reset while BUSY: no done, outputs cleared, fresh transaction afterwards
    b.if_req = 1'b1;
    b.if_addr = 32'h500;
    tick();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rstb_mem_req", {31'd0, b.mem_req}, 32'd0);
    check("rstb_mem_addr", b.mem_addr, 32'd0);
    check("rstb_if_rdata", b.if_rdata, 32'd0);
    check("rstb_d_rdata", b.d_rdata, 32'd0);
    rst = 1'b1;
    tick();
    check("rstb_restart", {31'd0, b.mem_req}, 32'd1);
    serve(2, 32'hCAFE0001, 1'b0, 32'h500, 1'b1);
    repeat (2) tick();

    // Held ack: pending request waits until ack has been sampled low
    b.d_req = 1'b1;
    b.d_addr = 32'h700;
    tick();
    sb.push_back('{1'b1, 1'b0, 32'h00000111});
    tick();
    b.ack = 1'b1;
    b.mem_rdata = 32'h00000111;
    tick();
    check("held_done", {31'd0, b.d_done}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("held_no_req", {31'd0, b.mem_req}, 32'd0);
    end
    b.ack = 1'b0;
    tick();
    check("held_still_idle", {31'd0, b.mem_req}, 32'd0);
    tick();
    check("held_regrant", {31'd0, b.mem_req}, 32'd1);
    serve(2, 32'h00000222, 1'b1, 32'h700, 1'b1);
    repeat (3) tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
